pipelined_segment_adder: RTL

//  Parametrised N-bit adder/subtractor built as a chain of SEG-bit segments, one pipeline stage per segment.

---
 rtl/pipelined_segment_adder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipelined_segment_adder.sv
// Segmented, fully pipelined N-bit adder/subtractor with valid/ready handshakes.
// Define PSA_SATURATE_EN to replace overflowing sums with signed saturation.

module psa_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
endmodule

module pipelined_segment_adder #(
  parameter int N   = 16,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int STAGES = N / SEG;

  logic [N-1:0]      b_eff;
  logic              cin_eff;
  logic              stall;
  logic [STAGES-1:0] vld_q;
  logic [STAGES:0]   vld_pipe;

  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = cin ^ sub;
  assign vld_pipe = {vld_q, in_valid};
  assign stall    = vld_pipe[STAGES] & ~out_ready;
  assign in_ready = ~stall;

  always_ff @(posedge clk) begin
    if (rst)         vld_q <= '0;
    else if (!stall) vld_q <= vld_pipe[STAGES-1:0];
  end

  // Stage k holds the operand segments still to be added and the finished low sum.
  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int WI = N - k*SEG;
    localparam int LO = (k+1)*SEG;

    logic [WI-1:0]  a_i, b_i;
    logic           ci;
    logic [SEG-1:0] seg_s;
    logic           seg_c;
    logic [LO-1:0]  s_w, s_d, s_q;
    logic           c_q;

    if (k == 0) begin : g_src
      assign a_i = a;
      assign b_i = b_eff;
      assign ci  = cin_eff;
      assign s_w = seg_s;
    end else begin : g_src
      assign a_i = stg[k-1].g_fwd.a_q;
      assign b_i = stg[k-1].g_fwd.b_q;
      assign ci  = stg[k-1].c_q;
      assign s_w = {seg_s, stg[k-1].s_q};
    end

    psa_seg #(.SEG(SEG)) u_seg (
      .a (a_i[SEG-1:0]),
      .b (b_i[SEG-1:0]),
      .ci(ci),
      .s (seg_s),
      .co(seg_c)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (!stall) begin
        s_q <= s_d;
        c_q <= seg_c;
      end
    end

    if (k < STAGES-1) begin : g_fwd
      logic [WI-SEG-1:0] a_q, b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_i[WI-1:SEG];
          b_q <= b_i[WI-1:SEG];
        end
      end
      assign s_d = s_w;
    end else begin : g_fin
      logic ovf_d, ovf_q;
      always_comb begin
        ovf_d = (a_i[SEG-1] == b_i[SEG-1]) & (seg_s[SEG-1] != a_i[SEG-1]);
        s_d   = s_w;
`ifdef PSA_SATURATE_EN
        // Overflow direction follows the sign of a: 0 -> max positive, 1 -> min negative.
        if (ovf_d) s_d = {a_i[SEG-1], {(LO-1){~a_i[SEG-1]}}};
`endif
      end
      always_ff @(posedge clk) begin
        if (rst)         ovf_q <= 1'b0;
        else if (!stall) ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = stg[STAGES-1].s_q;
  assign cout      = stg[STAGES-1].c_q;
  assign ovf       = stg[STAGES-1].g_fin.ovf_q;

endmodule
